// File: rtl/hamming15_dec_if.sv
// Valid/ready bundle for the Hamming(15,11) decoder: codeword in, corrected data and status out.
interface hamming15_dec_if;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] in_cw;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_data;
    logic [3:0]  out_syn;
    logic        out_err;
    logic        out_par_err;

    modport slave (
        input  in_valid, in_cw, out_ready,
        output in_ready, out_valid, out_data, out_syn, out_err, out_par_err
    );

    modport master (
        output in_valid, in_cw, out_ready,
        input  in_ready, out_valid, out_data, out_syn, out_err, out_par_err
    );
endinterface

// File: rtl/hamming15_dec.sv
// Two-stage registered Hamming(15,11) SEC decoder with full valid/ready backpressure.
// Define HAMMING15_DEC_ERR_CNT_EN to add the saturating corrected-beat counter (cnt_clr/corr_cnt).
module hamming15_dec
`ifdef HAMMING15_DEC_ERR_CNT_EN
    #(parameter int CNT_W = 16)
`endif
    (
    input  logic           clock,
    input  logic           reset_n,
    hamming15_dec_if.slave bus
`ifdef HAMMING15_DEC_ERR_CNT_EN
    ,
    input  logic           cnt_clr,
    output logic [CNT_W-1:0] corr_cnt
`endif
    );

    typedef struct packed {
        logic [10:0] data;
        logic [3:0]  syn;
        logic        err;
        logic        par_err;
    } rsp_t;

    logic [2:1]  vld_pipe;
    logic [14:0] s1_cw;
    logic [3:0]  s1_syn;
    logic [14:0] corr;
    rsp_t        rsp_d;
    rsp_t        rsp_q;
    logic        s1_load;
    logic        s2_load;

    // XOR of the positions of all set bits: zero for a valid codeword, else the flipped position.
    function automatic logic [3:0] syndrome(input logic [14:0] cw);
        logic [3:0] s;
        s = '0;
        for (int p = 1; p <= 15; p++)
            if (cw[p-1]) s = s ^ 4'(p);
        return s;
    endfunction

    assign s2_load      = ~vld_pipe[2] | bus.out_ready;
    assign s1_load      = ~vld_pipe[1] | s2_load;
    assign bus.in_ready = s1_load;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe[1] <= 1'b0;
            s1_cw       <= '0;
            s1_syn      <= '0;
        end else if (s1_load) begin
            vld_pipe[1] <= bus.in_valid;
            if (bus.in_valid) begin
                s1_cw  <= bus.in_cw;
                s1_syn <= syndrome(bus.in_cw);
            end
        end
    end

    always_comb begin
        corr = s1_cw;
        if (s1_syn != 4'd0) corr[s1_syn - 4'd1] = ~corr[s1_syn - 4'd1];
        rsp_d.data    = {corr[14:8], corr[6:4], corr[2]};
        rsp_d.syn     = s1_syn;
        rsp_d.err     = |s1_syn;
        // Power-of-two syndrome means only a check bit was hit.
        rsp_d.par_err = (|s1_syn) && ((s1_syn & (s1_syn - 4'd1)) == 4'd0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe[2] <= 1'b0;
            rsp_q       <= '0;
        end else if (s2_load) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) rsp_q <= rsp_d;
        end
    end

    assign bus.out_valid   = vld_pipe[2];
    assign bus.out_data    = rsp_q.data;
    assign bus.out_syn     = rsp_q.syn;
    assign bus.out_err     = rsp_q.err;
    assign bus.out_par_err = rsp_q.par_err;

`ifdef HAMMING15_DEC_ERR_CNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            corr_cnt <= '0;
        else if (cnt_clr)
            corr_cnt <= '0;
        else if (bus.out_valid && bus.out_ready && rsp_q.err && (corr_cnt != '1))
            corr_cnt <= corr_cnt + CNT_W'(1);
    end
`endif

endmodule
